// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID/EXE/MEM/WB pipeline. It handles load-use hazards, divide
// occupancy, cache stalls, mispredict redirects and exceptions. Define PIPE_STALL_PERF_EN to add Stall_Cnt.
module pipe_hazard_ctrl #(
    parameter int DIV_LAT = 32,
    parameter int PERF_W  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ID_Valid,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_ReadRs,
    input  logic       ID_ReadRt,
    input  logic       EXE_Valid,
    input  logic       EXE_IsLoad,
    input  logic [4:0] EXE_Dst,
    input  logic       EXE_DivStart,
    input  logic       EXE_Mispredict,
    input  logic       MEM_ExcValid,
    input  logic       ICache_Busy,
    input  logic       DCache_Busy,
    output logic       PC_Wr,
    output logic       ID_Wr,
    output logic       EXE_Wr,
    output logic       MEM_Wr,
    output logic       WB_Wr,
    output logic       ID_Flush,
    output logic       EXE_Flush,
    output logic       MEM_Flush,
    output logic       WB_Flush,
    output logic [1:0] Redirect_Sel,
    output logic       Div_Busy
`ifdef PIPE_STALL_PERF_EN
    ,
    output logic [PERF_W-1:0] Stall_Cnt
`endif
);

    localparam int              CW       = $clog2(DIV_LAT);
    localparam logic [CW-1:0]   DIV_LOAD = CW'(DIV_LAT - 1);
    localparam logic [1:0]      SEL_NONE = 2'd0;
    localparam logic [1:0]      SEL_BR   = 2'd1;
    localparam logic [1:0]      SEL_EXC  = 2'd2;

    typedef enum logic {IDLE, DIV} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] div_cnt, div_cnt_nxt;
    logic          pend_mis, pend_mis_nxt;
    logic          div_hold, div_hold_nxt;
    logic          div_start, div_busy_int, div_done, load_use, eff_mis;

    assign load_use = EXE_Valid & EXE_IsLoad & (EXE_Dst != 5'd0) & ID_Valid &
                      ((ID_ReadRs & (ID_rs == EXE_Dst)) | (ID_ReadRt & (ID_rt == EXE_Dst)));
    assign eff_mis  = EXE_Mispredict | pend_mis;

    // The divide that just finished still sits in EXE until EXE_Wr moves it on, so div_hold
    // blocks a restart until then.
    assign div_start    = (state == IDLE) & ~div_hold & EXE_DivStart & EXE_Valid &
                          ~MEM_ExcValid & ~DCache_Busy;
    assign div_busy_int = (state == DIV) | div_start;
    assign div_done     = (state == DIV) & ~DCache_Busy & (div_cnt == CW'(1));

    // NOTE: every output gets a default before the priority chain, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        PC_Wr        = 1'b1;
        ID_Wr        = 1'b1;
        EXE_Wr       = 1'b1;
        MEM_Wr       = 1'b1;
        WB_Wr        = 1'b1;
        ID_Flush     = 1'b0;
        EXE_Flush    = 1'b0;
        MEM_Flush    = 1'b0;
        WB_Flush     = 1'b0;
        Redirect_Sel = SEL_NONE;
        Div_Busy     = div_busy_int;
        if (rst) begin
            PC_Wr     = 1'b0;
            ID_Wr     = 1'b0;
            EXE_Wr    = 1'b0;
            MEM_Wr    = 1'b0;
            WB_Wr     = 1'b0;
            ID_Flush  = 1'b1;
            EXE_Flush = 1'b1;
            MEM_Flush = 1'b1;
            WB_Flush  = 1'b1;
            Div_Busy  = 1'b0;
        end else if (MEM_ExcValid) begin
            ID_Flush     = 1'b1;
            EXE_Flush    = 1'b1;
            MEM_Flush    = 1'b1;
            WB_Wr        = 1'b0;
            Redirect_Sel = SEL_EXC;
        end else if (DCache_Busy) begin
            PC_Wr    = 1'b0;
            ID_Wr    = 1'b0;
            EXE_Wr   = 1'b0;
            MEM_Wr   = 1'b0;
            WB_Flush = 1'b1;
        end else if (div_busy_int) begin
            PC_Wr     = 1'b0;
            ID_Wr     = 1'b0;
            EXE_Wr    = 1'b0;
            MEM_Flush = 1'b1;
        end else begin
            if (load_use) begin
                PC_Wr     = 1'b0;
                ID_Wr     = 1'b0;
                EXE_Flush = 1'b1;
            end else if (ICache_Busy) begin
                PC_Wr    = 1'b0;
                ID_Flush = 1'b1;
            end
            // A redirect kills the wrong-path fetch in ID and must still move the PC.
            if (eff_mis) begin
                ID_Flush     = 1'b1;
                PC_Wr        = 1'b1;
                Redirect_Sel = SEL_BR;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        div_cnt_nxt  = div_cnt;
        pend_mis_nxt = pend_mis;
        div_hold_nxt = div_hold;
        if (MEM_ExcValid) begin
            state_nxt    = IDLE;
            div_cnt_nxt  = '0;
            pend_mis_nxt = 1'b0;
            div_hold_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        state_nxt   = DIV;
                        div_cnt_nxt = DIV_LOAD;
                    end
                end
                DIV: begin
                    if (!DCache_Busy) begin
                        div_cnt_nxt = div_cnt - CW'(1);
                        if (div_done) state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (div_done)
                div_hold_nxt = 1'b1;
            else if (EXE_Wr || EXE_Flush)
                div_hold_nxt = 1'b0;
            pend_mis_nxt = (DCache_Busy || div_busy_int) ? eff_mis : 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            pend_mis <= 1'b0;
            div_hold <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_cnt_nxt;
            pend_mis <= pend_mis_nxt;
            div_hold <= div_hold_nxt;
        end
    end

`ifdef PIPE_STALL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            Stall_Cnt <= '0;
        else if (!PC_Wr)
            Stall_Cnt <= Stall_Cnt + PERF_W'(1);
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed output vectors checked half a cycle after each edge.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ID_Valid, ID_ReadRs, ID_ReadRt, EXE_Valid, EXE_IsLoad, EXE_DivStart;
    logic       EXE_Mispredict, MEM_ExcValid, ICache_Busy, DCache_Busy;
    logic [4:0] ID_rs, ID_rt, EXE_Dst;
    logic       PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr;
    logic       ID_Flush, EXE_Flush, MEM_Flush, WB_Flush, Div_Busy;
    logic [1:0] Redirect_Sel;
`ifdef PIPE_STALL_PERF_EN
    logic [31:0] Stall_Cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Vector order: PC,ID,EXE,MEM,WB _Wr | ID,EXE,MEM,WB _Flush | Redirect_Sel[1:0] | Div_Busy
    localparam logic [11:0] NORM   = 12'b1111_1000_0000;
    localparam logic [11:0] RSTV   = 12'b0000_0111_1000;
    localparam logic [11:0] LU     = 12'b0011_1010_0000;
    localparam logic [11:0] DIVB   = 12'b0001_1001_0001;
    localparam logic [11:0] DCDIV  = 12'b0000_1000_1001;
    localparam logic [11:0] DC     = 12'b0000_1000_1000;
    localparam logic [11:0] EXCDIV = 12'b1111_0111_0101;
    localparam logic [11:0] EXC    = 12'b1111_0111_0100;
    localparam logic [11:0] MIS    = 12'b1111_1100_0010;
    localparam logic [11:0] IC     = 12'b0111_1100_0000;
    localparam logic [11:0] LUMIS  = 12'b1011_1110_0010;

    pipe_hazard_ctrl #(.DIV_LAT(32), .PERF_W(32)) dut (
        .clk(clk), .rst(rst),
        .ID_Valid(ID_Valid), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_ReadRs(ID_ReadRs), .ID_ReadRt(ID_ReadRt),
        .EXE_Valid(EXE_Valid), .EXE_IsLoad(EXE_IsLoad), .EXE_Dst(EXE_Dst),
        .EXE_DivStart(EXE_DivStart), .EXE_Mispredict(EXE_Mispredict),
        .MEM_ExcValid(MEM_ExcValid), .ICache_Busy(ICache_Busy), .DCache_Busy(DCache_Busy),
        .PC_Wr(PC_Wr), .ID_Wr(ID_Wr), .EXE_Wr(EXE_Wr), .MEM_Wr(MEM_Wr), .WB_Wr(WB_Wr),
        .ID_Flush(ID_Flush), .EXE_Flush(EXE_Flush), .MEM_Flush(MEM_Flush), .WB_Flush(WB_Flush),
        .Redirect_Sel(Redirect_Sel), .Div_Busy(Div_Busy)
`ifdef PIPE_STALL_PERF_EN
        , .Stall_Cnt(Stall_Cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] exp);
        logic [11:0] obs;
        obs = {PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr, ID_Flush, EXE_Flush, MEM_Flush, WB_Flush,
               Redirect_Sel, Div_Busy};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ID_Valid = 0; ID_ReadRs = 0; ID_ReadRt = 0; ID_rs = 0; ID_rt = 0;
        EXE_Valid = 0; EXE_IsLoad = 0; EXE_Dst = 0; EXE_DivStart = 0; EXE_Mispredict = 0;
        MEM_ExcValid = 0; ICache_Busy = 0; DCache_Busy = 0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();

        // reset and idle
        tick(); #1 chk("reset_outputs", RSTV);
        tick(); rst = 0; #1 chk("idle_default", NORM);

        // load-use on rs, then released
        tick(); EXE_Valid = 1; EXE_IsLoad = 1; EXE_Dst = 5; ID_Valid = 1; ID_rs = 5; ID_ReadRs = 1;
        #1 chk("load_use_rs", LU);
        tick(); EXE_IsLoad = 0; #1 chk("load_use_release", NORM);
        // r0 never hazards; rt path honours ReadRt
        tick(); EXE_IsLoad = 1; EXE_Dst = 0; ID_rs = 0; #1 chk("load_use_r0", NORM);
        tick(); EXE_Dst = 7; ID_rs = 1; ID_ReadRs = 0; ID_rt = 7; ID_ReadRt = 1; #1 chk("load_use_rt", LU);
        tick(); ID_ReadRt = 0; #1 chk("load_use_rt_unread", NORM);
        tick(); ID_ReadRt = 1; EXE_Mispredict = 1; #1 chk("load_use_plus_mispredict", LUMIS);
        tick(); clear_inputs(); ICache_Busy = 1; #1 chk("icache_busy", IC);
        tick(); EXE_Mispredict = 1; #1 chk("icache_plus_mispredict", MIS);

        // mispredict while DCache busy is deferred then replayed
        tick(); clear_inputs(); DCache_Busy = 1; EXE_Mispredict = 1; #1 chk("mis_during_dcache", DC);
        tick(); EXE_Mispredict = 0; #1 chk("mis_pending_held", DC);
        tick(); DCache_Busy = 0; #1 chk("mis_replay", MIS);
        tick(); #1 chk("mis_replay_done", NORM);

        // divide: exactly 32 busy cycles, no restart on the finished DIV
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i == 0) begin EXE_Valid = 1; EXE_DivStart = 1; end
            #1 chk("div_busy", DIVB);
        end
        tick(); #1 chk("div_end_no_retrigger", NORM);
        tick(); EXE_DivStart = 0; #1 chk("div_after", NORM);

        // divide blocked by DCache at start, then stretched by 3 DCache cycles; mispredict deferred
        tick(); EXE_DivStart = 1; DCache_Busy = 1; #1 chk("div_start_blocked", DC);
        for (int i = 0; i < 35; i++) begin
            tick();
            DCache_Busy = (i >= 10 && i < 13);
            EXE_Mispredict = (i == 5);
            #1 chk(DCache_Busy ? "div_dcache_stall" : "div_stretch_busy", DCache_Busy ? DCDIV : DIVB);
        end
        tick(); EXE_Mispredict = 0; DCache_Busy = 0; #1 chk("div_end_mis_replay", MIS);
        tick(); EXE_DivStart = 0; #1 chk("div2_after", NORM);

        // exception at div_cnt==10 aborts divide and drops a pending mispredict
        for (int i = 0; i < 22; i++) begin
            tick();
            EXE_DivStart = 1;
            EXE_Mispredict = (i == 15);
            #1 chk("div3_busy", DIVB);
        end
        tick(); EXE_Mispredict = 0; MEM_ExcValid = 1; #1 chk("exc_mid_div", EXCDIV);
        tick(); MEM_ExcValid = 0; EXE_DivStart = 0; #1 chk("exc_after", NORM);

        // reset mid-divide with a pending mispredict
        for (int i = 0; i < 5; i++) begin
            tick();
            EXE_DivStart = 1;
            EXE_Mispredict = (i == 2);
            #1 chk("div4_busy", DIVB);
        end
        tick(); EXE_Mispredict = 0; rst = 1; #1 chk("rst_mid_div", RSTV);
        tick(); rst = 0; EXE_DivStart = 0; #1 chk("rst_after", NORM);
`ifdef PIPE_STALL_PERF_EN
        tests++;
        assert (Stall_Cnt === 32'd0) else begin
            fails++;
            $error("FAIL stall_cnt_reset: observed %0d expected 0", Stall_Cnt);
        end
`endif

        // exception outside a divide
        tick(); MEM_ExcValid = 1; #1 chk("exc_idle", EXC);
        tick(); MEM_ExcValid = 0; #1 chk("exc_idle_after", NORM);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
